// File: rtl/identity_checker.sv
// Clocked stimulus sweeper and response checker for pairs of Boolean expressions.
// Drives every N-bit vector, lets it settle, and compares the two responses.
module identity_checker #(
  parameter int unsigned N      = 3,
  parameter int unsigned SETTLE = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         lhs,
  input  logic         rhs,
  output logic [N-1:0] vec,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   err_count,
  output logic [N-1:0] first_fail_vec
);

  localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);
  localparam logic [N-1:0]  VEC_LAST = {N{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_COMPARE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] settle_cnt;
  logic          fail_seen;

  // Case inequality so an X/Z response is reported as a mismatch.
  logic       mismatch_c;
  logic [N:0] err_next_c;

  assign mismatch_c = (lhs !== rhs);
  assign err_next_c = mismatch_c ? err_count + (N+1)'(1) : err_count;

  // Sweep controller: settle each vector, compare once, advance or finish.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      settle_cnt     <= '0;
      fail_seen      <= 1'b0;
      vec            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_fail_vec <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state          <= S_SETTLE;
            settle_cnt     <= '0;
            fail_seen      <= 1'b0;
            vec            <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_fail_vec <= '0;
          end
        end
        S_SETTLE: begin
          if (settle_cnt == CNT_LAST) begin
            state      <= S_COMPARE;
            settle_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + CW'(1);
          end
        end
        S_COMPARE: begin
          err_count <= err_next_c;
          if (mismatch_c && !fail_seen) begin
            first_fail_vec <= vec;
            fail_seen      <= 1'b1;
          end
          if (vec == VEC_LAST) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next_c == '0);
          end else begin
            state <= S_SETTLE;
            vec   <= vec + N'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
